// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-in/parallel-out receiver.
//   Samples sin on each shift strobe, MSB first. It assembles WIDTH-bit
//   frames and hands each completed word to a consumer through a
//   single-entry valid/ready holding register. A sticky flag records any
//   word that is dropped because the holding register is still full.
// Optional feature macro: PARITY_CHECK_EN
//   When defined, each frame is WIDTH data bits followed by one even-parity
//   bit. parity_err then reports odd total ones for the held word.
//   When undefined, parity_err is tied to 0.
// Ports:
//   clk, clr              clock, asynchronous active-high reset
//   shift, sin, sync      bit strobe, serial bit, start-of-frame marker
//   po, bit_cnt           live assembly register and bit count in the frame
//   dout, dout_valid      held word and its valid flag
//   dout_ready            consumer accepts dout
//   overrun, parity_err   sticky drop flag, parity status of the held word
module sipo_deframer #(
  parameter int WIDTH = 6,
  parameter int CW    = $clog2(WIDTH+2)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift,
  input  logic             sin,
  input  logic             sync,
  output logic [WIDTH-1:0] po,
  output logic [CW-1:0]    bit_cnt,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  logic [WIDTH-1:0] po_q, po_d, dout_q, dout_d, word;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic             valid_q, valid_d, ovr_q, ovr_d, perr_q, perr_d;
  logic             complete, load, word_perr;

  always_comb begin
    // A sync-qualified bit always begins a fresh frame.
    cnt_base = sync ? '0 : cnt_q;
    complete = shift & (cnt_base == LAST);
    po_d     = shift ? {po_q[WIDTH-2:0], sin} : po_q;
    cnt_d    = cnt_q;
    if (shift) cnt_d = complete ? '0 : cnt_base + CW'(1);

`ifdef PARITY_CHECK_EN
    // The last bit is parity, so the data bits are already in po.
    word      = po_q;
    word_perr = ^{po_q, sin};
`else
    word      = {po_q[WIDTH-2:0], sin};
    word_perr = 1'b0;
`endif

    // Load when the register is empty or is being drained in the same cycle.
    load    = complete & (~valid_q | dout_ready);
    dout_d  = load ? word : dout_q;
    perr_d  = load ? word_perr : perr_q;
    valid_d = complete ? 1'b1 : (valid_q & ~dout_ready);
    ovr_d   = ovr_q | (complete & valid_q & ~dout_ready);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      po_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      po_q    <= po_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign po         = po_q;
  assign bit_cnt    = cnt_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule
